// File: rtl/mips_pkg.sv
// Opcode, funct and instruction-field constants shared by the fetch stage, hazard unit and decoders.
package mips_pkg;
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    localparam int OPC_HI = 31, OPC_LO = 26;
    localparam int RS_HI  = 25, RS_LO  = 21;
    localparam int RT_HI  = 20, RT_LO  = 16;
    localparam int RD_HI  = 15, RD_LO  = 11;
    localparam int FN_HI  = 5,  FN_LO  = 0;
    localparam int IMM_HI = 15, IMM_LO = 0;
    localparam int IDX_HI = 25, IDX_LO = 0;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

    function automatic logic signed [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction
endpackage

// File: rtl/fetch_fd_stage_npc_calc.sv
// Next-PC selection for the fetch stage: resolves beq/j/jal/jr held in D using forwarded operands.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] ir_d,
    input  logic [31:0] pc4_d,
    input  logic [31:0] pc_f,
    input  logic [31:0] rs_val_d,
    input  logic [31:0] rt_val_d,
    input  logic        stall,
    output logic [31:0] npc,
    output logic        redirect
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               beq_taken;
    logic               is_jump;
    logic               is_jr;
    logic signed [31:0] br_off;

    assign opcode    = ir_d[OPC_HI:OPC_LO];
    assign funct     = ir_d[FN_HI:FN_LO];
    assign beq_taken = (opcode == OP_BEQ) && (rs_val_d == rt_val_d);
    assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_jr     = (opcode == OP_SPECIAL) && (funct == FN_JR);
    assign br_off    = sext16(ir_d[IMM_HI:IMM_LO]) <<< 2;

    // A stall freezes the PC even when a branch is pending; it re-resolves next cycle.
    always_comb begin
        npc = pc_f + 32'd4;
        if (stall)
            npc = pc_f;
        else if (beq_taken)
            npc = pc4_d + br_off;
        else if (is_jump)
            npc = {pc4_d[31:28], ir_d[IDX_HI:IDX_LO], 2'b00};
        else if (is_jr)
            npc = rs_val_d;
    end

    assign redirect = (beq_taken || is_jump || is_jr) && !stall;
endmodule

// File: rtl/fetch_fd_stage.sv
// Fetch stage and F/D pipeline register with one branch delay slot (no flush).
// Optional FETCH_RANGE_CHECK_EN: illegal fetch addresses load a nop and set sticky fetch_err.
module fetch_fd_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic [31:0] rs_val_d,
    input  logic [31:0] rt_val_d,
    output logic [31:0] ir_d,
    output logic [31:0] pc4_d,
    output logic [31:0] pc8_d,
    output logic        redirect,
    output logic [31:0] fetch_cnt,
`ifdef FETCH_RANGE_CHECK_EN
    output logic        fetch_err,
`endif
    output logic [31:0] stall_cnt
);
    logic [31:0] pc_f;
    logic [31:0] npc;
    logic [31:0] ir_next;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    npc_calc u_npc (
        .ir_d     (ir_d),
        .pc4_d    (pc4_d),
        .pc_f     (pc_f),
        .rs_val_d (rs_val_d),
        .rt_val_d (rt_val_d),
        .stall    (stall),
        .npc      (npc),
        .redirect (redirect)
    );

    assign im_addr = pc_f;

`ifdef FETCH_RANGE_CHECK_EN
    localparam logic [31:0] IM_END = IM_BASE + 32'(4 * IM_WORDS);
    logic illegal;

    assign illegal = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f >= IM_END);
    assign ir_next = illegal ? 32'h0 : im_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fetch_err <= 1'b0;
        else if (!stall && illegal)
            fetch_err <= 1'b1;
    end
`else
    assign ir_next = im_rdata;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_f      <= PC_RESET;
            ir_d      <= 32'h0;
            pc4_d     <= PC_RESET;
            pc8_d     <= PC_RESET + 32'd4;
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            pc_f <= npc;
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end else begin
                ir_d      <= ir_next;
                pc4_d     <= pc_f + 32'd4;
                pc8_d     <= pc_f + 32'd8;
                fetch_cnt <= sat_inc(fetch_cnt);
            end
        end
    end
endmodule
